i2c_slave_ctrl: RTL and testbench



---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_slave_sync.sv | 36 +++
 rtl/i2c_slave_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM states, bit-counter width, R/W position and ACK levels.
package i2c_pkg;

  localparam int unsigned BitCntW  = 3;
  localparam int unsigned RwBitPos = 0;
  localparam logic        AckLevel  = 1'b0;
  localparam logic        NackLevel = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } slave_state_e;

endpackage

// File: rtl/i2c_slave_sync.sv
// Two-flop synchronizers for SCL/SDA plus SCL edge and START/STOP detection.
module i2c_slave_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  // [0] metastable stage, [1] synchronized level, [2] previous synchronized level
  logic [2:0] r_scl;
  logic [2:0] r_sda;
  logic       w_scl_high;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scl <= 3'b111;
      r_sda <= 3'b111;
    end else begin
      r_scl <= {r_scl[1:0], i_scl};
      r_sda <= {r_sda[1:0], i_sda};
    end
  end

  assign w_scl_high = r_scl[1] & r_scl[2];
  assign o_sda      = r_sda[1];
  assign o_scl_rise = r_scl[1] & ~r_scl[2];
  assign o_scl_fall = ~r_scl[1] & r_scl[2];
  assign o_start    = w_scl_high & r_sda[2] & ~r_sda[1];
  assign o_stop     = w_scl_high & ~r_sda[2] & r_sda[1];

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target with 7-bit address match and 8-bit register pointer over a strobe port.
// Define I2C_SLAVE_AUTOINC_EN to advance REG_ADDR after each write and each ACKed read byte.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h21,
  parameter int unsigned SDA_HOLD   = 4
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WR,
  output logic       REG_RD,
  input  logic [7:0] REG_RDATA,
  output logic       BUSY
);

  localparam int unsigned HoldW = $clog2(SDA_HOLD + 1);

  slave_state_e       r_state, w_state_nxt;
  logic [BitCntW-1:0] r_cnt, w_cnt_nxt;
  logic [6:0]         r_shift, w_shift_nxt;
  logic [7:0]         r_tx, w_tx_nxt;
  logic               r_rw, w_rw_nxt;
  logic               r_oe, w_oe_nxt;
  logic [HoldW-1:0]   r_hold, w_hold_nxt;
  logic               r_pend, w_pend_nxt;
  logic [7:0]         r_reg_addr, w_addr_nxt;
  logic [7:0]         r_reg_wdata, w_wdata_nxt;
  logic               r_reg_wr, w_wr_nxt;
  logic               r_reg_rd, w_rd_nxt;
  logic               r_rd_dly;
  logic               r_busy, w_busy_nxt;
  logic [7:0]         w_rx_byte;

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_slave_sync u_sync (
    .i_clk      (iCLK),
    .i_rst      (iRST),
    .i_scl      (I2C_SCLK),
    .i_sda      (I2C_SDAT),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  assign w_rx_byte = {r_shift, w_sda};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_rw_nxt    = r_rw;
    w_oe_nxt    = r_oe;
    w_hold_nxt  = r_hold;
    w_pend_nxt  = r_pend;
    w_addr_nxt  = r_reg_addr;
    w_wdata_nxt = r_reg_wdata;
    w_wr_nxt    = 1'b0;
    w_rd_nxt    = 1'b0;
    w_busy_nxt  = r_busy;

    if (r_rd_dly) w_tx_nxt = REG_RDATA;
`ifdef I2C_SLAVE_AUTOINC_EN
    if (r_reg_wr) w_addr_nxt = r_reg_addr + 8'd1;
`endif

    // SDA only moves once the hold delay after an SCL fall has elapsed
    if (r_pend) begin
      if (r_hold == '0) begin
        w_pend_nxt = 1'b0;
        unique case (r_state)
          StAddrAck, StPtrAck, StWdataAck: w_oe_nxt = ~AckLevel;
          StRdata:                         w_oe_nxt = ~r_tx[7];
          default:                         w_oe_nxt = 1'b0;
        endcase
      end else begin
        w_hold_nxt = r_hold - 1'b1;
      end
    end

    if (w_stop) begin
      w_state_nxt = StIdle;
      w_oe_nxt    = 1'b0;
      w_pend_nxt  = 1'b0;
      w_busy_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt = StAddr;
      w_cnt_nxt   = '0;
      w_oe_nxt    = 1'b0;
      w_pend_nxt  = 1'b0;
    end else if (w_scl_fall) begin
      w_hold_nxt = HoldW'(SDA_HOLD - 1);
      w_pend_nxt = 1'b1;
    end else if (w_scl_rise) begin
      w_shift_nxt = w_rx_byte[6:0];
      w_cnt_nxt   = r_cnt + 1'b1;
      unique case (r_state)
        StAddr: begin
          if (r_cnt == BitCntW'(7)) begin
            if (w_rx_byte[7:1] == SLAVE_ADDR) begin
              w_state_nxt = StAddrAck;
              w_rw_nxt    = w_rx_byte[RwBitPos];
              w_rd_nxt    = w_rx_byte[RwBitPos];
              w_busy_nxt  = 1'b1;
            end else begin
              w_state_nxt = StIgnore;
            end
          end
        end
        StAddrAck: begin
          w_cnt_nxt   = '0;
          w_state_nxt = r_rw ? StRdata : StPtr;
        end
        StPtr: begin
          if (r_cnt == BitCntW'(7)) begin
            w_addr_nxt  = w_rx_byte;
            w_state_nxt = StPtrAck;
          end
        end
        StPtrAck, StWdataAck: begin
          w_cnt_nxt   = '0;
          w_state_nxt = StWdata;
        end
        StWdata: begin
          if (r_cnt == BitCntW'(7)) begin
            w_wdata_nxt = w_rx_byte;
            w_wr_nxt    = 1'b1;
            w_state_nxt = StWdataAck;
          end
        end
        StRdata: begin
          w_tx_nxt = {r_tx[6:0], 1'b1};
          if (r_cnt == BitCntW'(7)) w_state_nxt = StRdataAck;
        end
        StRdataAck: begin
          w_cnt_nxt = '0;
          if (w_sda == NackLevel) begin
            w_state_nxt = StIgnore;
          end else begin
`ifdef I2C_SLAVE_AUTOINC_EN
            w_addr_nxt = r_reg_addr + 8'd1;
`endif
            w_rd_nxt    = 1'b1;
            w_state_nxt = StRdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_tx        <= '1;
      r_rw        <= 1'b0;
      r_oe        <= 1'b0;
      r_hold      <= '0;
      r_pend      <= 1'b0;
      r_reg_addr  <= 8'h00;
      r_reg_wdata <= 8'h00;
      r_reg_wr    <= 1'b0;
      r_reg_rd    <= 1'b0;
      r_rd_dly    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_tx        <= w_tx_nxt;
      r_rw        <= w_rw_nxt;
      r_oe        <= w_oe_nxt;
      r_hold      <= w_hold_nxt;
      r_pend      <= w_pend_nxt;
      r_reg_addr  <= w_addr_nxt;
      r_reg_wdata <= w_wdata_nxt;
      r_reg_wr    <= w_wr_nxt;
      r_reg_rd    <= w_rd_nxt;
      r_rd_dly    <= r_reg_rd;
      r_busy      <= w_busy_nxt;
    end
  end

  assign I2C_SDAT  = r_oe ? 1'b0 : 1'bz;
  assign REG_ADDR  = r_reg_addr;
  assign REG_WDATA = r_reg_wdata;
  assign REG_WR    = r_reg_wr;
  assign REG_RD    = r_reg_rd;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: bus-master tasks, write-frame vector table, hand sequences.
module tb_i2c_slave_ctrl;

`ifdef I2C_SLAVE_AUTOINC_EN
  localparam bit Auto = 1'b1;
`else
  localparam bit Auto = 1'b0;
`endif
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_low;
  wire        sda;
  logic [7:0] reg_addr, reg_wdata, rdata;
  logic       reg_wr, reg_rd, busy;
  logic [7:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_slave_ctrl #(.SLAVE_ADDR(7'h21), .SDA_HOLD(4)) dut (
    .iCLK      (clk),
    .iRST      (rst),
    .I2C_SCLK  (scl),
    .I2C_SDAT  (sda),
    .REG_ADDR  (reg_addr),
    .REG_WDATA (reg_wdata),
    .REG_WR    (reg_wr),
    .REG_RD    (reg_rd),
    .REG_RDATA (rdata),
    .BUSY      (busy)
  );

  always @(posedge clk) if (reg_rd) rdata <= mem[reg_addr];

  // Strobe log: pulses are counted on rising edges, high cycles separately
  int         wr_n = 0, wr_hi = 0, rd_n = 0, rd_hi = 0;
  logic       wr_prev = 1'b0, rd_prev = 1'b0;
  logic [7:0] wr_la [16];
  logic [7:0] wr_ld [16];
  logic [7:0] rd_la [16];

  always @(negedge clk) begin
    if (reg_wr) begin
      wr_hi++;
      if (!wr_prev && wr_n < 16) begin
        wr_la[wr_n] = reg_addr;
        wr_ld[wr_n] = reg_wdata;
        wr_n++;
      end
    end
    if (reg_rd) begin
      rd_hi++;
      if (!rd_prev && rd_n < 16) begin
        rd_la[rd_n] = reg_addr;
        rd_n++;
      end
    end
    wr_prev = reg_wr;
    rd_prev = reg_rd;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_low = 1'b1; wait_q(); scl = 1'b0;
  endtask

  task automatic bus_restart();
    wait_q(); m_low = 1'b0; wait_q(); scl = 1'b1; wait_q(); m_low = 1'b1; wait_q(); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_q(); m_low = 1'b1; wait_q(); scl = 1'b1; wait_q(); m_low = 1'b0; wait_q();
  endtask

  task automatic bit_out(input logic b);
    wait_q(); m_low = ~b; wait_q(); scl = 1'b1; wait_q(); wait_q(); scl = 1'b0;
  endtask

  task automatic bit_in(output logic b);
    wait_q(); m_low = 1'b0; wait_q(); scl = 1'b1; wait_q(); b = sda; wait_q(); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) bit_in(d[i]);
    bit_out(nack);
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] ptr;
    logic [7:0] data;
    logic [2:0] exp_ack;
    logic       exp_busy;
    int         exp_wr;
    logic [7:0] exp_addr;
  } vec_t;

  vec_t       vec [4];
  logic [2:0] acks;
  logic       a0, a1, a2, a3;
  logic [7:0] rx;
  int         wr0, rd0;

  initial begin
    vec[0] = '{8'h42, 8'h10, 8'hA5, 3'b000, 1'b1, 1, Auto ? 8'h11 : 8'h10};
    vec[1] = '{8'h50, 8'h33, 8'h77, 3'b111, 1'b0, 0, Auto ? 8'h11 : 8'h10};
    vec[2] = '{8'h42, 8'hFE, 8'h3C, 3'b000, 1'b1, 1, Auto ? 8'hFF : 8'hFE};
    vec[3] = '{8'h20, 8'h01, 8'h02, 3'b111, 1'b0, 0, Auto ? 8'hFF : 8'hFE};
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[8'h10] = 8'h5A;

    rst = 1'b1; scl = 1'b1; m_low = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_reg_addr", 32'(reg_addr), 32'h00);
    check("reset_reg_wdata", 32'(reg_wdata), 32'h00);
    check("reset_strobes", {reg_wr, reg_rd}, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_sda", 32'(sda), 32'h1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      wr0 = wr_n;
      bus_start();
      send_byte(vec[v].dev, acks[2]);
      check($sformatf("v%0d_busy_mid", v), 32'(busy), 32'(vec[v].exp_busy));
      send_byte(vec[v].ptr, acks[1]);
      send_byte(vec[v].data, acks[0]);
      bus_stop();
      check($sformatf("v%0d_acks", v), 32'(acks), 32'(vec[v].exp_ack));
      check($sformatf("v%0d_wr_count", v), wr_n - wr0, vec[v].exp_wr);
      if (vec[v].exp_wr == 1 && wr_n > wr0) begin
        check($sformatf("v%0d_wr_addr", v), 32'(wr_la[wr0]), 32'(vec[v].ptr));
        check($sformatf("v%0d_wr_data", v), 32'(wr_ld[wr0]), 32'(vec[v].data));
      end
      check($sformatf("v%0d_reg_addr", v), 32'(reg_addr), 32'(vec[v].exp_addr));
      check($sformatf("v%0d_busy_end", v), 32'(busy), 32'h0);
    end

    // Combined read: pointer 0x10, repeated START, one byte, master NACK
    rd0 = rd_n;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h10, a1);
    bus_restart();
    send_byte(8'h43, a2);
    recv_byte(rx, 1'b1);
    check("rd_acks", {a0, a1, a2}, 32'h0);
    check("rd_data", 32'(rx), 32'h5A);
    check("rd_pulses", rd_n - rd0, 1);
    if (rd_n > rd0) check("rd_addr", 32'(rd_la[rd0]), 32'h10);
    wait_q(); wait_q();
    check("rd_sda_released", 32'(sda), 32'h1);
    bus_stop();
    check("rd_reg_addr", 32'(reg_addr), 32'h10);

    // Burst write across the pointer wrap
    wr0 = wr_n;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'hFF, a1);
    send_byte(8'h11, a2);
    send_byte(8'h22, a3);
    bus_stop();
    check("burst_acks", {a0, a1, a2, a3}, 32'h0);
    check("burst_wr_count", wr_n - wr0, 2);
    if (wr_n >= wr0 + 2) begin
      check("burst_wr0", {wr_la[wr0], wr_ld[wr0]}, 32'hFF11);
      check("burst_wr1", {wr_la[wr0+1], wr_ld[wr0+1]}, Auto ? 32'h0022 : 32'hFF22);
    end
    check("burst_reg_addr", 32'(reg_addr), Auto ? 32'h01 : 32'hFF);

    // STOP in the middle of a data byte
    wr0 = wr_n;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h33, a1);
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
    bus_stop();
    wait_q();
    check("midstop_acks", {a0, a1}, 32'h0);
    check("midstop_no_wr", wr_n - wr0, 0);
    check("midstop_busy", 32'(busy), 32'h0);
    check("midstop_sda", 32'(sda), 32'h1);
    check("midstop_reg_addr", 32'(reg_addr), 32'h33);

    // Reset while the slave is driving the address ACK
    bus_start();
    for (int i = 7; i >= 0; i--) bit_out(rx[i] ^ rx[i] ^ logic'((8'h42 >> i) & 8'h01));
    m_low = 1'b0;
    wait_q(); wait_q();
    check("rstack_slave_drives", 32'(sda), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstack_sda_released", 32'(sda), 32'h1);
    check("rstack_reg_addr", 32'(reg_addr), 32'h00);
    check("rstack_reg_wdata", 32'(reg_wdata), 32'h00);
    check("rstack_strobes_busy", {reg_wr, reg_rd, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_q(); scl = 1'b1; wait_q();

    check("wr_one_cycle", wr_hi, wr_n);
    check("rd_one_cycle", rd_hi, rd_n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
